data_memory_mmio: RTL and testbench

Parametrised successor to the single-port data memory. It provides byte/half/word loads and stores with sign or zero extension over a byte-lane RAM. It also decodes a memory-mapped I/O window holding N display registers and a read-only cycle counter. It sits in the memory stage, driven by the stage-2 microcode decode, and returns load data one enabled cycle after request.

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_byte_ram.sv | 33 +++
 rtl/data_memory_mmio.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_mmio.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory with MMIO window.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_DISP = 2'd1,
    REG_CNT  = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  localparam logic [31:0] CNT_OFFSET = 32'h0000_003C;

  // Lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] byte_enable(size_e size, logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Move the addressed lane(s) down to bit 0 and sign/zero extend.
  function automatic logic [31:0] extend_load(logic [31:0] word, size_e size,
                                              logic [1:0] off, logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
      SZ_WORD: res = sh;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Four byte-wide synchronous single-port RAM lanes with per-lane write enable.
module mem_byte_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Lane write on its enable; registered read when no lane is written.
    always_ff @(posedge clk_i) begin
      if (en_i) begin
        if (we_i[l]) begin
          mem_q[addr_i] <= wdata_i[8*l +: 8];
        end
        if (we_i == 4'b0000) begin
          rdata_q <= mem_q[addr_i];
        end
      end
    end

    assign rdata_o[8*l +: 8] = rdata_q;
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Byte/half/word data memory with display registers and a cycle counter mapped
// into an MMIO window. Load data returns one enabled cycle after the request.
module data_memory_mmio
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 11,
  parameter int unsigned NUM_DISPLAYS       = 1,
  parameter int unsigned DISPLAY_WIDTH      = 16,
  parameter bit          DISPLAY_ACTIVE_LOW = 1'b1,
  parameter logic [31:0] MMIO_BASE          = 32'h0000_0800
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clk_enable,
  input  logic                                  req_valid,
  input  logic                                  req_write,
  input  logic [1:0]                            req_size,
  input  logic                                  req_unsigned,
  input  logic [31:0]                           addr,
  input  logic [31:0]                           data_in,
  output logic                                  rsp_valid,
  output logic [31:0]                           data_out,
  output logic                                  misaligned,
  output logic [NUM_DISPLAYS*DISPLAY_WIDTH-1:0] display_out
);

  localparam int unsigned WAW         = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH       = 2 ** WAW;
  localparam logic [32:0] RAM_LIMIT   = 33'(1) << ADDR_WIDTH;
  localparam logic [29:0] DISP_BASE_W = MMIO_BASE[31:2];
  localparam logic [31:0] CNT_ADDR    = MMIO_BASE + CNT_OFFSET;

  size_e                    size_c;
  region_e                  region_c;
  logic [29:0]              disp_off_c;
  logic                     fault_c;
  logic [3:0]               be_c;
  logic [31:0]              lane_mask_c;
  logic [31:0]              wdata_c;
  logic [31:0]              mmio_rd_c;
  logic [DISPLAY_WIDTH-1:0] disp_wdata_c;
  logic                     accept_c;
  logic                     ram_en_c;
  logic [3:0]               ram_we_c;
  logic                     disp_we_c;
  logic [31:0]              ram_rdata;

  logic [DISPLAY_WIDTH-1:0] disp_q [NUM_DISPLAYS];
  logic [31:0]              cnt_q;
  logic                     rsp_valid_q;
  logic                     misaligned_q;
  logic                     zero_q;
  logic [1:0]               off_q;
  size_e                    size_q;
  logic                     uns_q;
  region_e                  region_q;
  logic [31:0]              mmio_q;

  assign size_c     = size_e'(req_size);
  assign disp_off_c = addr[31:2] - DISP_BASE_W;
  assign accept_c   = clk_enable & req_valid;

  // Region decode; RAM takes priority over the MMIO window.
  always_comb begin
    region_c = REG_NONE;
    if ({1'b0, addr} < RAM_LIMIT) begin
      region_c = REG_RAM;
    end else if (disp_off_c < 30'(NUM_DISPLAYS)) begin
      region_c = REG_DISP;
    end else if (addr == CNT_ADDR) begin
      region_c = REG_CNT;
    end
  end

  // Alignment check, lane enables and lane-replicated store data.
  always_comb begin
    case (size_c)
      SZ_HALF: fault_c = addr[0];
      SZ_WORD: fault_c = |addr[1:0];
      SZ_ILL:  fault_c = 1'b1;
      default: fault_c = 1'b0;
    endcase
    case (size_c)
      SZ_BYTE: wdata_c = {4{data_in[7:0]}};
      SZ_HALF: wdata_c = {2{data_in[15:0]}};
      default: wdata_c = data_in;
    endcase
    be_c        = byte_enable(size_c, addr[1:0]);
    lane_mask_c = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
  end

  // Current MMIO read value, also the base for display lane merges.
  always_comb begin
    mmio_rd_c = 32'h0;
    if (region_c == REG_CNT) begin
      mmio_rd_c = cnt_q;
    end else if (region_c == REG_DISP) begin
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        if (disp_off_c == 30'(i)) begin
          mmio_rd_c = 32'(disp_q[i]);
        end
      end
    end
    disp_wdata_c = DISPLAY_WIDTH'((mmio_rd_c & ~lane_mask_c) | (wdata_c & lane_mask_c));
  end

  assign ram_en_c  = rst_n & accept_c & ~fault_c & (region_c == REG_RAM);
  assign ram_we_c  = req_write ? be_c : 4'b0000;
  assign disp_we_c = accept_c & req_write & ~fault_c & (region_c == REG_DISP);

  mem_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (WAW)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en_c),
    .we_i    (ram_we_c),
    .addr_i  (addr[ADDR_WIDTH-1:2]),
    .wdata_i (wdata_c),
    .rdata_o (ram_rdata)
  );

  // Display registers: byte-lane writes, bits beyond the width are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        disp_q[i] <= '0;
      end
    end else if (disp_we_c) begin
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        if (disp_off_c == 30'(i)) begin
          disp_q[i] <= disp_wdata_c;
        end
      end
    end
  end

  // Free-running enabled-cycle counter and the one-cycle response stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= 32'h0;
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      zero_q       <= 1'b1;
      off_q        <= 2'b00;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      region_q     <= REG_NONE;
      mmio_q       <= 32'h0;
    end else if (clk_enable) begin
      cnt_q        <= cnt_q + 32'd1;
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      if (req_valid) begin
        if (fault_c) begin
          rsp_valid_q  <= 1'b1;
          misaligned_q <= 1'b1;
          zero_q       <= 1'b1;
        end else if (!req_write) begin
          rsp_valid_q <= 1'b1;
          zero_q      <= 1'b0;
          off_q       <= addr[1:0];
          size_q      <= size_c;
          uns_q       <= req_unsigned;
          region_q    <= region_c;
          mmio_q      <= mmio_rd_c;
        end
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign misaligned = misaligned_q;
  // Built only from registered state, so it holds between responses and stalls.
  assign data_out   = zero_q ? 32'h0
                    : extend_load((region_q == REG_RAM) ? ram_rdata : mmio_q,
                                  size_q, off_q, uns_q);

  for (genvar i = 0; i < NUM_DISPLAYS; i++) begin : g_disp_out
    assign display_out[i*DISPLAY_WIDTH +: DISPLAY_WIDTH] =
      DISPLAY_ACTIVE_LOW ? ~disp_q[i] : disp_q[i];
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Randomized bench for data_memory_mmio with a byte-addressed reference model.
module tb_data_memory_mmio;

  logic        clk;
  logic        rst_n;
  logic        clk_enable;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rsp_valid;
  logic [31:0] data_out;
  logic        misaligned;
  logic [31:0] display_out;

  data_memory_mmio #(
    .ADDR_WIDTH         (11),
    .NUM_DISPLAYS       (2),
    .DISPLAY_WIDTH      (16),
    .DISPLAY_ACTIVE_LOW (1'b1),
    .MMIO_BASE          (32'h0000_0800)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_enable   (clk_enable),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .data_in      (data_in),
    .rsp_valid    (rsp_valid),
    .data_out     (data_out),
    .misaligned   (misaligned),
    .display_out  (display_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: RAM as bytes, displays as values, counter as a number.
  logic [7:0]  ram_b [2048];
  bit          ram_k [2048];
  logic [31:0] m_disp [2];
  logic [31:0] m_cnt;
  logic [31:0] c0;
  logic        exp_rv, exp_mis, exp_chk;
  logic [31:0] exp_data;
  bit          model_ready = 1'b0;

  task automatic model_req(input logic [31:0] cnt_now);
    int n, rg, idx, bp;
    bit flt, known;
    logic [7:0]  b;
    logic [31:0] v;
    n   = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
    flt = (req_size == 2'd3) || ((addr % 32'(n)) != 0);
    if (addr < 32'd2048)                             rg = 0;
    else if (addr >= 32'h800 && addr < 32'h808)      rg = 1;
    else if (addr == 32'h83C)                        rg = 2;
    else                                             rg = 3;
    idx = int'((addr - 32'h800) / 4);
    if (flt) begin
      exp_rv = 1'b1; exp_mis = 1'b1; exp_data = 32'h0; exp_chk = !req_write;
      return;
    end
    if (req_write) begin
      for (int k = 0; k < n; k++) begin
        b = data_in[8*k +: 8];
        if (rg == 0) begin
          ram_b[addr + 32'(k)] = b;
          ram_k[addr + 32'(k)] = 1'b1;
        end else if (rg == 1) begin
          bp = int'(addr % 4) + k;
          m_disp[idx][8*bp +: 8] = b;
          m_disp[idx] &= 32'h0000_FFFF;
        end
      end
    end else begin
      v = 32'h0; known = 1'b1;
      for (int k = 0; k < n; k++) begin
        case (rg)
          0: begin
            if (ram_k[addr + 32'(k)]) b = ram_b[addr + 32'(k)];
            else begin b = 8'h0; known = 1'b0; end
          end
          1: begin
            bp = int'(addr % 4) + k;
            b  = 8'(m_disp[idx] >> (8*bp));
          end
          2:       b = 8'(cnt_now >> (8*k));
          default: b = 8'h0;
        endcase
        v |= 32'(b) << (8*k);
      end
      if (!req_unsigned && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
      exp_rv = 1'b1; exp_mis = 1'b0; exp_data = v; exp_chk = known;
    end
  endtask

  always @(posedge clk) begin
    model_ready = 1'b1;
    if (!rst_n) begin
      exp_rv = 1'b0; exp_mis = 1'b0; exp_data = 32'h0; exp_chk = 1'b1;
      m_disp[0] = 32'h0; m_disp[1] = 32'h0; m_cnt = 32'h0;
    end else if (clk_enable) begin
      c0    = m_cnt;
      m_cnt = m_cnt + 32'd1;
      exp_rv = 1'b0; exp_mis = 1'b0;
      if (req_valid) model_req(c0);
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("misaligned", 32'(misaligned), 32'(exp_mis));
      if (exp_chk) chk("data_out", data_out, exp_data);
      chk("display_out", display_out, ~{m_disp[1][15:0], m_disp[0][15:0]});
    end
  end

  task automatic req(input bit w, input bit [1:0] sz, input bit u,
                     input bit [31:0] a, input bit [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    addr = a; data_in = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int r;
    rst_n = 1'b0; clk_enable = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; addr = 32'h0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_data", data_out, 32'h0);
    chk("reset_disp", display_out, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    // Word, byte and half accesses over one RAM word.
    req(1, 2, 0, 32'h10, 32'hDEAD_BEEF);
    req(0, 2, 0, 32'h10, 32'h0);
    chk("lw_rv", 32'(rsp_valid), 32'd1);
    chk("lw_mis", 32'(misaligned), 32'd0);
    chk("lw_data", data_out, 32'hDEAD_BEEF);
    req(1, 0, 0, 32'h13, 32'h0000_0080);
    req(0, 0, 0, 32'h13, 32'h0);
    chk("lb_sext", data_out, 32'hFFFF_FF80);
    req(0, 0, 1, 32'h13, 32'h0);
    chk("lbu", data_out, 32'h0000_0080);
    req(0, 2, 0, 32'h10, 32'h0);
    chk("lw_after_sb", data_out, 32'h80AD_BEEF);
    req(1, 1, 0, 32'h12, 32'h0000_1234);
    req(0, 1, 1, 32'h12, 32'h0);
    chk("lhu", data_out, 32'h0000_1234);
    req(0, 1, 0, 32'h11, 32'h0);
    chk("lh_mis", 32'(misaligned), 32'd1);
    chk("lh_mis_data", data_out, 32'h0);
    req(0, 2, 0, 32'h10, 32'h0);
    chk("lw_after_sh", data_out, 32'h1234_BEEF);

    // Display registers.
    req(1, 2, 0, 32'h804, 32'h0000_A5A5);
    chk("disp1_out", 32'(display_out[31:16]), 32'h0000_5A5A);
    req(0, 2, 0, 32'h804, 32'h0);
    chk("disp1_rd", data_out, 32'h0000_A5A5);
    req(1, 0, 0, 32'h800, 32'h0000_00FF);
    chk("disp0_out", 32'(display_out[15:0]), 32'h0000_FF00);

    // Counter after reset, ignored counter write, stall hold.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    req(0, 2, 0, 32'h83C, 32'h0);
    chk("cnt10", data_out, 32'd10);
    req(1, 2, 0, 32'h83C, 32'h0);
    req(0, 2, 0, 32'h83C, 32'h0);
    chk("cnt12", data_out, 32'd12);
    clk_enable = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; addr = 32'h10; data_in = 32'h0;
    repeat (5) @(negedge clk);
    chk("stall_rv", 32'(rsp_valid), 32'd1);
    chk("stall_data", data_out, 32'd12);
    req_valid = 1'b0; clk_enable = 1'b1;
    req(0, 2, 0, 32'h83C, 32'h0);
    chk("cnt13", data_out, 32'd13);
    req(0, 2, 0, 32'h10, 32'h0);
    chk("stall_no_wr", data_out, 32'h1234_BEEF);

    // Reset right after an accepted load.
    req(0, 2, 0, 32'h10, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_disp", display_out, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    req(0, 2, 0, 32'h83C, 32'h0);
    chk("rst_cnt", data_out, 32'd0);
    req(0, 2, 0, 32'h10, 32'h0);
    chk("ram_kept", data_out, 32'h1234_BEEF);

    // Randomized traffic.
    for (int w = 0; w < 16; w++) req(1, 2, 0, 32'(w * 4), $urandom);
    req(1, 2, 0, 32'h7FC, $urandom);
    for (int it = 0; it < 3000; it++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      clk_enable = ($urandom_range(0, 7) != 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = $urandom_range(0, 1) == 1;
      req_unsigned = $urandom_range(0, 1) == 1;
      r = int'($urandom_range(0, 7));
      req_size = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      r = int'($urandom_range(0, 9));
      if (r < 7)       addr = 32'($urandom_range(0, 63));
      else if (r == 7) addr = 32'h7FC + 32'($urandom_range(0, 3));
      else if (r == 8) addr = 32'h800 + 32'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 5))
          0: addr = 32'h83C;
          1: addr = 32'h83D;
          2: addr = 32'h808;
          3: addr = 32'h840;
          4: addr = 32'h1000;
          default: addr = 32'hFFFF_FFFC;
        endcase
      end
      if ($urandom_range(0, 1) == 1) begin
        if (req_size == 2'd1) addr[0] = 1'b0;
        if (req_size == 2'd2) addr[1:0] = 2'b00;
      end
      data_in = $urandom;
      @(negedge clk);
    end
    rst_n = 1'b1; clk_enable = 1'b1; req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
